// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_pkg                                                    |
// | Purpose  : Shared widths, defaults and FSM encoding for the Wishbone |
// |            single-transfer initiator and its helpers.                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package wb_pkg;

  localparam int WB_ADR_W       = 8;
  localparam int WB_DAT_W       = 32;
  localparam int WB_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_mst_state_t;

  // Counter width able to hold LIMIT, never narrower than one bit.
  function automatic int ctr_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_bus_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_bus_master_if                                          |
// | Purpose  : Command/response handshake plus Wishbone classic signals  |
// |            for a single-transfer initiator.                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface wb_bus_master_if import wb_pkg::*; #(
  parameter int ADR_W = WB_ADR_W,
  parameter int DAT_W = WB_DAT_W
);

  // Command side
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [ADR_W-1:0] cmd_adr;
  logic [DAT_W-1:0] cmd_dat;

  // Response side
  logic             rsp_valid;
  logic [DAT_W-1:0] rsp_dat;
  logic             rsp_timeout;

  // Wishbone side
  logic [ADR_W-1:0] ADR_O;
  logic [DAT_W-1:0] DAT_O;
  logic             WE_O;
  logic             CYC_O;
  logic             STB_O;
  logic [DAT_W-1:0] DAT_I;
  logic             ACK_I;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, DAT_I, ACK_I,
    output cmd_ready, rsp_valid, rsp_dat, rsp_timeout,
    output ADR_O, DAT_O, WE_O, CYC_O, STB_O
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, DAT_I, ACK_I,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_timeout,
    input  ADR_O, DAT_O, WE_O, CYC_O, STB_O
  );

endinterface
`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_timeout_ctr                                            |
// | Purpose  : Saturating wait counter. 'expired' flags the edge on which|
// |            the count would reach LIMIT; LIMIT = 0 never expires.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module wb_timeout_ctr import wb_pkg::*; #(
  parameter int LIMIT = WB_TIMEOUT_DEF
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  clear,
  input  wire  enable,
  output logic expired
);

  localparam int              CNT_W = ctr_width(LIMIT);
  localparam logic [CNT_W-1:0] c_max = '1;

  logic [CNT_W-1:0] r_cnt;

  // Count enabled cycles; clear wins, and the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (LIMIT == 0) begin : g_no_limit
      assign expired = 1'b0;
    end else begin : g_limit
      localparam logic [CNT_W-1:0] c_last = CNT_W'(LIMIT - 1);
      // Combinational look-ahead so the owner can leave on the very edge
      // where the count becomes LIMIT.
      assign expired = enable && (r_cnt == c_last);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_bus_master                                             |
// | Purpose  : Turns one command handshake into one Wishbone classic     |
// |            read or write, with ACK or timeout reported as a response.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module wb_bus_master import wb_pkg::*; #(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
  input wire              CLK_I,
  input wire              RST_I,
  wb_bus_master_if.master bus
);

  wb_mst_state_t    r_state;
  logic [ADR_W-1:0] r_adr;
  logic [DAT_W-1:0] r_dat_o;
  logic             r_we;
  logic             r_cyc;
  logic             r_stb;
  logic             r_rsp_valid;
  logic [DAT_W-1:0] r_rsp_dat;
  logic             r_rsp_timeout;

  logic w_accept;
  logic w_wait;
  logic w_expired;

  // Ready only in IDLE and held low for the whole reset interval.
  assign bus.cmd_ready = (r_state == IDLE) && !RST_I;

  assign w_accept = bus.cmd_valid && (r_state == IDLE);
  assign w_wait   = (r_state == BUS) && !bus.ACK_I;

  wb_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (CLK_I),
    .rst     (RST_I),
    .clear   (w_accept),
    .enable  (w_wait),
    .expired (w_expired)
  );

  // Transfer FSM; every bus and response output is registered here.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state       <= IDLE;
      r_adr         <= '0;
      r_dat_o       <= '0;
      r_we          <= 1'b0;
      r_cyc         <= 1'b0;
      r_stb         <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_dat     <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_accept) begin
            r_state <= BUS;
            r_adr   <= bus.cmd_adr;
            r_we    <= bus.cmd_we;
            r_dat_o <= bus.cmd_we ? bus.cmd_dat : '0;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
          end
        end
        BUS: begin
          // ACK takes priority over a timeout landing on the same edge.
          if (bus.ACK_I) begin
            r_state       <= RESP;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_dat     <= r_we ? '0 : bus.DAT_I;
            r_rsp_timeout <= 1'b0;
          end else if (w_expired) begin
            r_state       <= RESP;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_dat     <= '0;
            r_rsp_timeout <= 1'b1;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_cyc       <= 1'b0;
          r_stb       <= 1'b0;
          r_we        <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ADR_O       = r_adr;
  assign bus.DAT_O       = r_dat_o;
  assign bus.WE_O        = r_we;
  assign bus.CYC_O       = r_cyc;
  assign bus.STB_O       = r_stb;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_dat     = r_rsp_dat;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire
